// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the random range capture path
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_OUT_WIDTH = 8;

    // Loop stops at 30 so the signed shift never wraps negative.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_remainder.sv
// rtl/seq_remainder.sv - serial restoring modulo, one dividend bit per cycle
module seq_remainder
    import rng_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RANGE = 6,
    parameter int REM_W = clog2(RANGE) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             done,
    output logic [REM_W-1:0] rem
);

    localparam int IDX_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [REM_W:0] RANGE_T = (REM_W + 1)'(RANGE);

    logic [WIDTH-1:0] snap_q, snap_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             active_q, active_d;
    logic [REM_W:0]   t;
    logic [REM_W-1:0] rem_nxt;

    // Dividend is consumed MSB first by shifting the snapshot left.
    assign t       = {rem_q, snap_q[WIDTH-1]};
    assign rem_nxt = REM_W'((t >= RANGE_T) ? (t - RANGE_T) : t);
    assign done    = active_q && (idx_q == '0);
    assign rem     = rem_nxt;

    always_comb begin
        snap_d   = snap_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        active_d = active_q;
        if (start) begin
            snap_d   = dividend;
            rem_d    = '0;
            idx_d    = IDX_W'(WIDTH - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            snap_d = snap_q << 1;
            rem_d  = rem_nxt;
            idx_d  = idx_q - 1'b1;
            if (idx_q == '0) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q   <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            snap_q   <= snap_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/random_range_capture.sv
// rtl/random_range_capture.sv - snapshot counter on enable release, map into [MIN_VAL, MAX_VAL]
module random_range_capture
    import rng_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     counter_value,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] rand_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 dropped
);

    localparam int RANGE = MAX_VAL - MIN_VAL + 1;
    localparam int REM_W = clog2(RANGE) + 1;

    state_t               state_q, state_d;
    logic                 last_enable_q, last_enable_d;
    logic [OUT_WIDTH-1:0] rand_out_q, rand_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 dropped_q, dropped_d;
    logic                 fall;
    logic                 start;
    logic                 div_done;
    logic [REM_W-1:0]     rem;

    assign fall = last_enable_q & ~enable;

    seq_remainder #(
        .WIDTH (WIDTH),
        .RANGE (RANGE),
        .REM_W (REM_W)
    ) u_rem (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (counter_value),
        .done     (div_done),
        .rem      (rem)
    );

    always_comb begin
        state_d       = state_q;
        last_enable_d = enable;
        rand_out_d    = rand_out_q;
        out_valid_d   = out_valid_q;
        dropped_d     = 1'b0;
        start         = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    start   = 1'b1;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                dropped_d = fall;
                if (div_done) begin
                    state_d     = DONE;
                    rand_out_d  = OUT_WIDTH'(MIN_VAL) + OUT_WIDTH'(rem);
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // Capture only ever starts from IDLE, so a fall on the accept edge is lost too.
                dropped_d = fall;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_enable_q <= 1'b0;
            rand_out_q    <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_enable_q <= last_enable_d;
            rand_out_q    <= rand_out_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            dropped_q     <= dropped_d;
        end
    end

    assign rand_out  = rand_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dropped   = dropped_q;

endmodule

// File: doc/random_range_capture.md
Name: random_range_capture

Overview:
Consumer end of the counter's enable/count interface. It watches the same enable level that drives the counter and, on enable's falling edge (button release), snapshots counter_value. It reduces the snapshot into [MIN_VAL, MAX_VAL] using a serial restoring modulo, one bit per cycle. The result is presented on a valid/ready output toward the display/UART path.

Parameters:
WIDTH, 32, width of counter_value and of the captured snapshot
OUT_WIDTH, 8, width of rand_out
MIN_VAL, 1, lowest output value
MAX_VAL, 6, highest output value; must satisfy MAX_VAL >= MIN_VAL and MAX_VAL < 2**OUT_WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; block held in reset while 0
enable  in  1  same enable level that drives the counter; synchronous to clk
counter_value  in  WIDTH  running count from the counter
out_ready  in  1  downstream accepts rand_out when high with out_valid
rand_out  out  OUT_WIDTH  mapped random value
out_valid  out  1  rand_out holds a result
busy  out  1  high while a capture is being reduced or waiting for acceptance (state != IDLE)
dropped  out  1  one-cycle pulse when a falling edge is ignored

Behaviour:
- Reset (reset=0, async): state=IDLE, last_enable=0, rand_out=0, out_valid=0, busy=0, dropped=0, remainder=0, bit index=0.
- Derived constant RANGE = MAX_VAL-MIN_VAL+1. Remainder register width REM_W = clog2(RANGE)+1.
- Fall detect: fall = last_enable & ~enable. last_enable <= enable every cycle, in every state.
- IDLE: on fall at edge N, snapshot <= counter_value, remainder <= 0, bit index <= WIDTH-1, state <= DIVIDE.
- DIVIDE: at each of edges N+1..N+WIDTH, do one step:
  - t = {remainder, snapshot[bit index]};
  - remainder <= (t >= RANGE) ? t-RANGE : t;
  - decrement bit index.
- On the step with bit index 0 (edge N+WIDTH), state <= DONE, rand_out <= MIN_VAL + final remainder, out_valid <= 1.
- Latency: out_valid is first visible after edge N+WIDTH, i.e. WIDTH cycles after the capture edge.
- DONE: rand_out and out_valid stay stable until out_ready=1 at a rising edge. At that edge out_valid <= 0 and state <= IDLE. rand_out keeps its last value after acceptance.
- A fall in DIVIDE or DONE is not captured: dropped=1 for exactly that cycle, and the in-flight result is unaffected.
- A fall in the same cycle as DONE acceptance is also dropped, because capture happens only from IDLE.
- Snapshot value 0 gives remainder 0, so rand_out=MIN_VAL.
- RANGE=1 always gives rand_out=MIN_VAL. The full WIDTH-cycle latency still applies.
- Enable held high, or held low, produces no activity.
- Reset asserted mid-DIVIDE or in DONE aborts immediately to the reset values; no partial result is ever emitted.
- All arithmetic is unsigned. The MIN_VAL + remainder addition is done at OUT_WIDTH; no overflow is possible given the parameter constraint.

Decomposition:
- Shared package (rng_pkg) holds:
  - state typedef (IDLE, DIVIDE, DONE);
  - a clog2 function;
  - default WIDTH and OUT_WIDTH constants, shared with the counter.
- One natural sub-module, seq_remainder:
  - ports: start, dividend[WIDTH], a RANGE parameter, done, rem[REM_W];
  - owns the bit index, snapshot shift and compare/subtract.
- The top keeps fall detection, the handshake FSM and the MIN_VAL offset.

Test Plan:
- Dice defaults: enable high, counter_value=7, drop enable -> after 32 cycles out_valid=1, rand_out=2; out_ready=1 one cycle -> out_valid=0, busy=0.
- counter_value=32'hFFFF_FFFF at fall -> rand_out=4 (4294967295 mod 6 = 3, plus 1); counter_value=0 -> rand_out=1; counter_value=12 -> rand_out=1; counter_value=11 -> rand_out=6.
- Backpressure: result ready with out_ready=0 for 10 cycles -> rand_out and out_valid stable every cycle; accepted on the first edge with out_ready=1.
- Second fall 5 cycles after the first (counter_value=9) -> dropped pulses once, and the first result (7 -> 2) is emitted unchanged; a fall on the acceptance cycle is also dropped.
- reset=0 at cycle 16 of DIVIDE -> all outputs 0 immediately; after release, out_valid stays 0 with no fall; a fresh fall with counter_value=5 -> rand_out=6.
- MIN_VAL=0, MAX_VAL=255, OUT_WIDTH=8: counter_value=32'h0000_1234 -> rand_out=8'h34 after 32 cycles.
